// File: rtl/dsp_chain_operand_feeder_pkg.sv
// rtl/dsp_chain_operand_feeder_pkg.sv - shared constants and helpers for the DSP chain operand feeder
// Purpose: operand width, lane slicing, fp16 constants and valid-pipe length helper.
// Ports: none (package).
package dsp_chain_operand_feeder_pkg;

  localparam int FP_W           = 16;
  localparam int DEF_NUM_STAGES = 3;

  // One lane carries one fp16 operand; a lane bundle carries top_a/top_b/bot_a/bot_b.
  localparam int LANE_W        = FP_W;
  localparam int LANE_BUNDLE_W = 4 * FP_W;

  localparam logic [FP_W-1:0] FP16_ZERO = 16'h0000;
  localparam logic [FP_W-1:0] FP16_ONE  = 16'h3C00;

  // Low bit of lane k inside an operand bus.
  function automatic int lane_lsb(input int k);
    return k * LANE_W;
  endfunction

  // Cycles from the accept edge to the chain's final result.
  function automatic int feeder_pipe_len(input int num_stages, input int stage_lat,
                                         input int chain_lat);
    return 1 + (num_stages - 1) * stage_lat + chain_lat;
  endfunction

endpackage

// File: rtl/dsp_feeder_skew_pipe.sv
// rtl/dsp_feeder_skew_pipe.sv - DEPTH x WIDTH register delay line with async reset
// Purpose: fixed-latency delay used for per-lane operand skew and the result valid pipe.
// Ports: clk_i clock; rst_i async active-high reset; d_i input word; q_o word delayed DEPTH cycles.
module dsp_feeder_skew_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/dsp_chain_operand_feeder.sv
// rtl/dsp_chain_operand_feeder.sv - operand skew, result valid and credit throttle for the fp16 DSP chain
// Purpose: accepts one operand beat per cycle, skews lane k by 1+k*STAGE_LAT cycles to match
//   the chainout cascade, strobes res_valid when the chain result is ready, and limits beats
//   in flight plus buffered to CREDITS.
// Ports: clk, reset (async active-high); in_valid/in_ready beat handshake;
//   in_top_a/in_top_b/in_bot_a/in_bot_b lane-packed operands in; top_a/top_b/bot_a/bot_b skewed
//   operands out; res_valid result strobe; res_pop returns a credit; credit_err sticky underflow;
//   beat_cnt accepted-beat count (only when DSP_FEEDER_BEAT_CNT_EN is defined).
module dsp_chain_operand_feeder
  import dsp_chain_operand_feeder_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int STAGE_LAT  = 1,
  parameter int CHAIN_LAT  = 2,
  parameter int CREDITS    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_STAGES*FP_W-1:0] in_top_a,
  input  logic [NUM_STAGES*FP_W-1:0] in_top_b,
  input  logic [NUM_STAGES*FP_W-1:0] in_bot_a,
  input  logic [NUM_STAGES*FP_W-1:0] in_bot_b,
  output logic [NUM_STAGES*FP_W-1:0] top_a,
  output logic [NUM_STAGES*FP_W-1:0] top_b,
  output logic [NUM_STAGES*FP_W-1:0] bot_a,
  output logic [NUM_STAGES*FP_W-1:0] bot_b,
  output logic                       res_valid,
  input  logic                       res_pop,
  output logic                       credit_err
`ifdef DSP_FEEDER_BEAT_CNT_EN
  ,
  output logic [31:0]                beat_cnt
`endif
);

  localparam int PIPE_L = feeder_pipe_len(NUM_STAGES, STAGE_LAT, CHAIN_LAT);
  localparam int CNT_W  = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CREDITS_MAX = CNT_W'(CREDITS);

  logic             accept;
  logic             pop_ok;
  logic [CNT_W-1:0] credits_q, credits_d;
  logic             credit_err_q, credit_err_d;

  assign in_ready = (credits_q != '0);
  assign accept   = in_valid & in_ready;

  // The first register of each lane pipe is the stage-0 capture register; it loads zeros
  // when nothing is accepted so the chain only ever sums zero products for idle cycles.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_lane
    logic [LANE_BUNDLE_W-1:0] lane_d;
    logic [LANE_BUNDLE_W-1:0] lane_q;

    assign lane_d = accept ? {in_top_a[lane_lsb(k) +: FP_W], in_top_b[lane_lsb(k) +: FP_W],
                              in_bot_a[lane_lsb(k) +: FP_W], in_bot_b[lane_lsb(k) +: FP_W]}
                           : {4{FP16_ZERO}};

    dsp_feeder_skew_pipe #(
      .DEPTH (1 + k * STAGE_LAT),
      .WIDTH (LANE_BUNDLE_W)
    ) u_lane_pipe (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (lane_d),
      .q_o   (lane_q)
    );

    assign {top_a[lane_lsb(k) +: FP_W], top_b[lane_lsb(k) +: FP_W],
            bot_a[lane_lsb(k) +: FP_W], bot_b[lane_lsb(k) +: FP_W]} = lane_q;
  end

  dsp_feeder_skew_pipe #(
    .DEPTH (PIPE_L),
    .WIDTH (1)
  ) u_valid_pipe (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (accept),
    .q_o   (res_valid)
  );

  // A pop with a full credit pool has no matching result; count it as an error, not a credit.
  always_comb begin
    credits_d    = credits_q;
    pop_ok       = res_pop && (credits_q != CREDITS_MAX);
    credit_err_d = credit_err_q | (res_pop && (credits_q == CREDITS_MAX));
    case ({accept, pop_ok})
      2'b10:   credits_d = credits_q - 1'b1;
      2'b01:   credits_d = credits_q + 1'b1;
      default: credits_d = credits_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      credits_q    <= CREDITS_MAX;
      credit_err_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign credit_err = credit_err_q;

`ifdef DSP_FEEDER_BEAT_CNT_EN
  logic [31:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (accept) beat_cnt_d = beat_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) beat_cnt_q <= 32'd0;
    else       beat_cnt_q <= beat_cnt_d;
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_chain_operand_feeder.sv
// tb/tb_dsp_chain_operand_feeder.sv - self-checking bench for dsp_chain_operand_feeder
module tb_dsp_chain_operand_feeder;
  import dsp_chain_operand_feeder_pkg::*;

  localparam int BW = 3 * FP_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_top_a = '0, in_top_b = '0, in_bot_a = '0, in_bot_b = '0;
  logic [BW-1:0] top_a, top_b, bot_a, bot_b;
  logic          res_valid;
  logic          res_pop = 1'b0;
  logic          credit_err;
`ifdef DSP_FEEDER_BEAT_CNT_EN
  logic [31:0]   beat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_chain_operand_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_top_a   (in_top_a),
    .in_top_b   (in_top_b),
    .in_bot_a   (in_bot_a),
    .in_bot_b   (in_bot_b),
    .top_a      (top_a),
    .top_b      (top_b),
    .bot_a      (bot_a),
    .bot_b      (bot_b),
    .res_valid  (res_valid),
    .res_pop    (res_pop),
    .credit_err (credit_err)
`ifdef DSP_FEEDER_BEAT_CNT_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  typedef struct {
    logic       in_valid;
    logic       res_pop;
    logic [2:0] lanes;     // lanes expected to carry the operand pattern this cycle
    logic       exp_rv;
    logic       exp_ready;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(input logic v, input logic p, input logic [2:0] l,
                              input logic rv, input logic rdy);
    vec_t r;
    r.in_valid = v; r.res_pop = p; r.lanes = l; r.exp_rv = rv; r.exp_ready = rdy;
    return r;
  endfunction

  function automatic logic [BW-1:0] lanes_bus(input logic [2:0] l, input logic [FP_W-1:0] v);
    logic [BW-1:0] b;
    b = '0;
    for (int k = 0; k < 3; k++) if (l[k]) b[k*FP_W +: FP_W] = v;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1; in_valid = 1'b0; res_pop = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic apply_rows(input int lo, input int hi, input logic [FP_W-1:0] bot_v);
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("row%0d top_a", i), 64'(top_a), 64'(lanes_bus(vt[i].lanes, FP16_ONE)));
      chk($sformatf("row%0d top_b", i), 64'(top_b), 64'(lanes_bus(vt[i].lanes, 16'h4000)));
      chk($sformatf("row%0d bot_a", i), 64'(bot_a), 64'(lanes_bus(vt[i].lanes, bot_v)));
      chk($sformatf("row%0d bot_b", i), 64'(bot_b), 64'd0);
      chk($sformatf("row%0d res_valid", i), 64'(res_valid), 64'(vt[i].exp_rv));
      chk($sformatf("row%0d in_ready", i), 64'(in_ready), 64'(vt[i].exp_ready));
      in_valid = vt[i].in_valid;
      res_pop  = vt[i].res_pop;
      step();
    end
    in_valid = 1'b0;
    res_pop  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen_rv;

    // Single beat: rows 0..7 are cycles 0..7 with the accept at the end of cycle 0.
    vt[0]  = mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    vt[1]  = mk(1'b0, 1'b0, 3'b001, 1'b0, 1'b1);
    vt[2]  = mk(1'b0, 1'b0, 3'b010, 1'b0, 1'b1);
    vt[3]  = mk(1'b0, 1'b0, 3'b100, 1'b0, 1'b1);
    vt[4]  = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    vt[5]  = mk(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);
    vt[6]  = mk(1'b0, 1'b1, 3'b000, 1'b0, 1'b1);
    vt[7]  = mk(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
    // Credit exhaustion: in_valid held, four accepts, then one pop re-opens a single slot.
    vt[8]  = mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    vt[9]  = mk(1'b1, 1'b0, 3'b001, 1'b0, 1'b1);
    vt[10] = mk(1'b1, 1'b0, 3'b011, 1'b0, 1'b1);
    vt[11] = mk(1'b1, 1'b0, 3'b111, 1'b0, 1'b1);
    vt[12] = mk(1'b1, 1'b0, 3'b111, 1'b0, 1'b0);
    vt[13] = mk(1'b1, 1'b0, 3'b110, 1'b1, 1'b0);
    vt[14] = mk(1'b1, 1'b0, 3'b100, 1'b1, 1'b0);
    vt[15] = mk(1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    vt[16] = mk(1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    vt[17] = mk(1'b1, 1'b1, 3'b000, 1'b0, 1'b0);
    vt[18] = mk(1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    vt[19] = mk(1'b0, 1'b0, 3'b001, 1'b0, 1'b0);

    in_top_a = {3{FP16_ONE}};
    in_top_b = {3{16'h4000}};

    reset_dut();
    chk("reset credit_err", 64'(credit_err), 64'd0);
    chk("reset credits", 64'(dut.credits_q), 64'd4);
    apply_rows(0, 7, 16'h0000);

    in_bot_a = {3{16'h1234}};
    reset_dut();
    apply_rows(8, 19, 16'h1234);
    in_bot_a = '0;

    // Accept and pop together with two credits outstanding.
    reset_dut();
    in_valid = 1'b1;
    step();
    step();
    res_pop = 1'b1;
    step();
    in_valid = 1'b0;
    res_pop  = 1'b0;
    chk("simul credits", 64'(dut.credits_q), 64'd2);
    chk("simul in_ready", 64'(in_ready), 64'd1);

    // Pop with a full pool sets a sticky error and leaves the count alone.
    reset_dut();
    res_pop = 1'b1;
    step();
    res_pop = 1'b0;
    chk("spurious err next", 64'(credit_err), 64'd1);
    step(); step(); step();
    chk("spurious err sticky", 64'(credit_err), 64'd1);
    chk("spurious credits", 64'(dut.credits_q), 64'd4);

    // Reset two cycles after an accept kills the in-flight beat.
    reset_dut();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("midflight pre top_a", 64'(top_a), 64'(lanes_bus(3'b010, FP16_ONE)));
    #2 reset = 1'b1;
    #1;
    chk("midflight async top_a", 64'(top_a), 64'd0);
    chk("midflight async top_b", 64'(top_b), 64'd0);
    chk("midflight async credits", 64'(dut.credits_q), 64'd4);
    @(posedge clk);
    #1 reset = 1'b0;
    seen_rv = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      seen_rv = seen_rv | res_valid;
    end
    chk("midflight no res_valid", 64'(seen_rv), 64'd0);
    chk("midflight credits", 64'(dut.credits_q), 64'd4);
    chk("midflight in_ready", 64'(in_ready), 64'd1);

`ifdef DSP_FEEDER_BEAT_CNT_EN
    reset_dut();
    in_valid = 1'b1;
    step();
    res_pop = 1'b1;
    for (int c = 0; c < 6; c++) step();
    in_valid = 1'b0;
    res_pop  = 1'b0;
    chk("beat_cnt seven", 64'(beat_cnt), 64'd7);
    force dut.beat_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.beat_cnt_q;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("beat_cnt wrap", 64'(beat_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
